// File: rtl/alarme_controle.sv
// alarme_controle: sequential arm/disarm controller downstream of the
// combinational alarme detector. Adds an entry-delay countdown, a timed siren
// with re-trigger while the alarm condition persists, and a saturating count
// of siren triggers.
//
// Ports:
//   clk       in   rising-edge system clock
//   rst       in   asynchronous reset, active-high
//   arm       in   arm request (level)
//   disarm    in   disarm request (level), overrides everything but rst
//   A         in   alarm condition from alarme, synchronous to clk
//   siren     out  siren drive (state == DISPARO)
//   armed     out  high in every state except DESARMADO
//   pending   out  high during the entry delay (ESPERA)
//   arm_fail  out  registered one-cycle pulse when an arm request is refused
//   state     out  current state encoding
//   eventos   out  siren trigger count, saturating at 15
module alarme_controle #(
   parameter int unsigned ENTRY_DELAY = 4,
   parameter int unsigned SIREN_TIME  = 6,
   parameter int unsigned CNT_W       = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       arm,
   input  logic       disarm,
   input  logic       A,
   output logic       siren,
   output logic       armed,
   output logic       pending,
   output logic       arm_fail,
   output logic [1:0] state,
   output logic [3:0] eventos
);

   localparam int unsigned EVT_W = 4;

   typedef enum logic [1:0] {
      DESARMADO = 2'd0,
      ARMADO    = 2'd1,
      ESPERA    = 2'd2,
      DISPARO   = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(ENTRY_DELAY - 1);
   localparam logic [CNT_W-1:0] SIREN_LOAD = CNT_W'(SIREN_TIME - 1);
   localparam logic [EVT_W-1:0] EVT_MAX    = '1;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [EVT_W-1:0] evt_q, evt_d;
   logic             arm_fail_q, arm_fail_d;

   // State, shared down-counter, event counter and refusal pulse registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= DESARMADO;
         cnt_q      <= '0;
         evt_q      <= '0;
         arm_fail_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         evt_q      <= evt_d;
         arm_fail_q <= arm_fail_d;
      end
   end

   // Next-state logic; disarm has priority over every other request
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      evt_d      = evt_q;
      arm_fail_d = 1'b0;

      if (disarm) begin
         state_d = DESARMADO;
         cnt_d   = '0;
      end else begin
         case (state_q)
            DESARMADO: begin
               // Arming is refused while the alarm condition is present
               if (arm) begin
                  if (A) arm_fail_d = 1'b1;
                  else   state_d    = ARMADO;
               end
            end
            ARMADO: begin
               if (A) begin
                  state_d = ESPERA;
                  cnt_d   = DELAY_LOAD;
               end
            end
            ESPERA: begin
               // A dropping does not cancel the delay; only disarm does
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CNT_W'(1);
               end else begin
                  state_d = DISPARO;
                  cnt_d   = SIREN_LOAD;
                  if (evt_q != EVT_MAX) evt_d = evt_q + EVT_W'(1);
               end
            end
            DISPARO: begin
               // A still high at end of burst re-arms the siren without a new event
               if (cnt_q != '0)  cnt_d   = cnt_q - CNT_W'(1);
               else if (A)       cnt_d   = SIREN_LOAD;
               else              state_d = ARMADO;
            end
            default: begin
               state_d = DESARMADO;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Moore outputs decoded from the state register
   assign siren    = (state_q == DISPARO);
   assign armed    = (state_q != DESARMADO);
   assign pending  = (state_q == ESPERA);
   assign arm_fail = arm_fail_q;
   assign state    = state_q;
   assign eventos  = evt_q;

endmodule

// File: tb/tb_alarme_controle.sv
// Directed testbench for alarme_controle with ENTRY_DELAY=4, SIREN_TIME=6.
module tb_alarme_controle;

   logic       clk;
   logic       rst;
   logic       arm;
   logic       disarm;
   logic       A;
   logic       siren;
   logic       armed;
   logic       pending;
   logic       arm_fail;
   logic [1:0] state;
   logic [3:0] eventos;

   int n_checks;
   int n_fail;

   alarme_controle #(
      .ENTRY_DELAY(4),
      .SIREN_TIME (6),
      .CNT_W      (8)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .arm     (arm),
      .disarm  (disarm),
      .A       (A),
      .siren   (siren),
      .armed   (armed),
      .pending (pending),
      .arm_fail(arm_fail),
      .state   (state),
      .eventos (eventos)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int unsigned act, input int unsigned exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   // Advance one rising edge and settle
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int exp_state;
      int exp_evt;
      n_checks = 0;
      n_fail   = 0;
      arm = 1'b0; disarm = 1'b0; A = 1'b0;
      rst = 1'b1;
      #1;
      check("rst_state",   32'(state),    0);
      check("rst_siren",   32'(siren),    0);
      check("rst_armed",   32'(armed),    0);
      check("rst_pending", 32'(pending),  0);
      check("rst_armfail", 32'(arm_fail), 0);
      check("rst_eventos", 32'(eventos),  0);
      step();
      rst = 1'b0;
      step();

      // Arm with no alarm
      arm = 1'b1;
      step();
      arm = 1'b0;
      check("arm_state",   32'(state),    1);
      check("arm_armed",   32'(armed),    1);
      check("arm_siren",   32'(siren),    0);
      check("arm_eventos", 32'(eventos),  0);
      check("arm_armfail", 32'(arm_fail), 0);

      // Single pulse of A: 4 cycles pending, 6 cycles siren, back to ARMADO
      A = 1'b1;
      step();
      A = 1'b0;
      check("k_pending", 32'(pending), 1);
      check("k_state",   32'(state),   2);
      for (int i = 1; i <= 10; i++) begin
         step();
         exp_state = (i <= 3) ? 2 : ((i <= 9) ? 3 : 1);
         check($sformatf("pulse_state_k+%0d", i), 32'(state), 32'(exp_state));
         check($sformatf("pulse_siren_k+%0d", i), 32'(siren), (exp_state == 3) ? 1 : 0);
         check($sformatf("pulse_pend_k+%0d", i),  32'(pending), (exp_state == 2) ? 1 : 0);
      end
      check("pulse_eventos", 32'(eventos), 1);

      // A held: siren continuous across reload, no extra event
      A = 1'b1;
      for (int i = 0; i <= 10; i++) begin
         step();
         exp_state = (i <= 3) ? 2 : 3;
         check($sformatf("hold_state_k+%0d", i), 32'(state), 32'(exp_state));
      end
      check("hold_siren_reload", 32'(siren),   1);
      check("hold_eventos",      32'(eventos), 2);
      A = 1'b0;
      for (int i = 11; i <= 16; i++) begin
         step();
         exp_state = (i <= 15) ? 3 : 1;
         check($sformatf("hold_state_k+%0d", i), 32'(state), 32'(exp_state));
      end
      check("hold_eventos_end", 32'(eventos), 2);

      // Disarm wins over arm while in ESPERA at counter=2
      A = 1'b1;
      step();
      A = 1'b0;
      step();
      check("esp_state", 32'(state), 2);
      arm = 1'b1; disarm = 1'b1;
      step();
      arm = 1'b0; disarm = 1'b0;
      check("dis_state",   32'(state),   0);
      check("dis_pending", 32'(pending), 0);
      check("dis_armed",   32'(armed),   0);
      check("dis_siren",   32'(siren),   0);
      for (int i = 0; i < 6; i++) begin
         step();
         check($sformatf("dis_quiet_siren_%0d", i), 32'(siren), 0);
         check($sformatf("dis_quiet_state_%0d", i), 32'(state), 0);
      end
      check("dis_eventos", 32'(eventos), 2);

      // Refused arm while A=1
      A = 1'b1; arm = 1'b1;
      step();
      check("fail1_armfail", 32'(arm_fail), 1);
      check("fail1_state",   32'(state),    0);
      step();
      check("fail2_armfail", 32'(arm_fail), 1);
      check("fail2_state",   32'(state),    0);
      A = 1'b0;
      step();
      check("fail3_state",   32'(state),    1);
      check("fail3_armfail", 32'(arm_fail), 0);
      arm = 1'b0;
      step();
      check("fail4_armfail", 32'(arm_fail), 0);

      // Async reset mid-DISPARO
      A = 1'b1;
      step();
      A = 1'b0;
      repeat (4) step();
      check("pre_rst_siren",   32'(siren),   1);
      check("pre_rst_eventos", 32'(eventos), 3);
      step();
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_siren",   32'(siren),   0);
      check("async_rst_state",   32'(state),   0);
      check("async_rst_eventos", 32'(eventos), 0);
      step();
      rst = 1'b0;
      step();

      // 16 bursts saturate eventos at 15
      arm = 1'b1;
      step();
      arm = 1'b0;
      check("sat_armed", 32'(state), 1);
      for (int b = 0; b < 16; b++) begin
         A = 1'b1;
         step();
         A = 1'b0;
         repeat (10) step();
         exp_evt = (b + 1 > 15) ? 15 : b + 1;
         check($sformatf("sat_eventos_%0d", b), 32'(eventos), 32'(exp_evt));
         check($sformatf("sat_state_%0d", b),   32'(state),   1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Watchdog: the directed sequence is short, so this only catches a hang
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/alarme_controle.md
Name: alarme_controle

Overview:
- Sequential stage directly downstream of the combinational `alarme` detector; consumes its alarm output `A`.
- Adds arm/disarm control, an entry-delay countdown, a timed siren with re-trigger, and a saturating trigger-event counter.
- Outputs drive the siren and the panel indicators.

Parameters:
- ENTRY_DELAY, 4, number of cycles spent in ESPERA before the siren fires; must be ≥1 and ≤2^CNT_W.
- SIREN_TIME, 6, number of cycles the siren stays on per burst; must be ≥1 and ≤2^CNT_W.
- CNT_W, 8, width of the shared down-counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- arm  in  1  arm request, level, sampled each edge.
- disarm  in  1  disarm request, level; overrides everything except rst.
- A  in  1  alarm condition from `alarme`; synchronous to clk.
- siren  out  1  siren drive.
- armed  out  1  high in every state except DESARMADO.
- pending  out  1  high during the entry delay (ESPERA).
- arm_fail  out  1  one-cycle pulse when an arm request is refused.
- state  out  2  current state encoding.
- eventos  out  4  count of siren triggers, saturating at 15.

Behaviour:
- Clock, reset and output timing
  - One clock; reset is asynchronous and active-high.
  - Clock port is `clk`, reset port is `rst`.
  - All outputs are registered or decoded from state only (Moore); there is no combinational path from an input to an output.
- Reset (async, immediate, including mid-delay or mid-siren):
  - state=DESARMADO, siren=0, armed=0, pending=0, arm_fail=0, eventos=0, counter=0.
- State encoding: DESARMADO=0, ARMADO=1, ESPERA=2, DISPARO=3.
- Decoded outputs:
  - siren = (state==DISPARO)
  - armed = (state!=DESARMADO)
  - pending = (state==ESPERA)
- Transition priority: disarm=1 in any state → DESARMADO on the next edge, counter cleared. This also applies when arm=1 in the same cycle: disarm wins.
- DESARMADO:
  - arm=1, disarm=0, A=0 → ARMADO.
  - arm=1, disarm=0, A=1 → stay in DESARMADO; arm_fail=1 for exactly one cycle.
  - arm held high with A=1 pulses arm_fail every cycle.
- ARMADO: A=1 → ESPERA, counter loaded with ENTRY_DELAY-1.
- ESPERA:
  - counter>0 → decrement.
  - counter==0 → DISPARO, counter loaded with SIREN_TIME-1, eventos incremented (saturating at 15).
  - A returning to 0 does NOT cancel the delay; only disarm cancels it.
- DISPARO:
  - counter>0 → decrement.
  - counter==0 and A=0 → ARMADO.
  - counter==0 and A=1 → stay in DISPARO, counter reloaded with SIREN_TIME-1, eventos NOT incremented.
- Latency:
  - A sampled high at edge k in ARMADO → pending=1 from edge k.
  - siren=1 from edge k+ENTRY_DELAY.
  - siren stays high for exactly SIREN_TIME cycles per burst.
- Counter width: CNT_W bits; never underflows, because it is only decremented when nonzero.
- arm_fail is a registered pulse; it is 0 in every other cycle.

Test Plan (ENTRY_DELAY=4, SIREN_TIME=6):
- Reset then arm=1 for 1 cycle with A=0 → state=1, armed=1, siren=0, eventos=0.
- Armed; A=1 at edge k, then A=0 → pending=1 for edges k..k+3; siren=1 for edges k+4..k+9; state=1 at edge k+10; eventos=1.
- Armed; A held at 1 throughout → siren continuously high across the reload at edge k+10; eventos stays 1.
- In ESPERA at counter=2, assert arm=1 and disarm=1 together → next edge state=0, pending=0, armed=0, siren never asserts.
- In DESARMADO with A=1, arm=1 for 2 cycles → arm_fail=1 on both edges, state stays 0; drop A, arm=1 → state=1, arm_fail=0.
- Assert rst asynchronously mid-DISPARO (between edges) → siren=0, state=0, eventos=0 immediately, with no clock edge needed. Additionally, 16 triggered bursts → eventos=15 (saturated).
